// File: rtl/csr_regfile_if.sv
// -----------------------------------------------------------------------------
// csr_regfile_if
//   CSR access port between the ex stage (master) and the CSR file (slave).
//   csr_req_i    : access valid this cycle
//   csr_we_i     : write intended
//   csr_op_i     : 01=RW, 10=RS, 11=RC, 00=no access
//   csr_addr_i   : 12-bit CSR address
//   csr_wdata_i  : rs1 / zimm operand
//   csr_rdata_o  : pre-write CSR value (combinational)
//   csr_illegal_o: illegal access (combinational)
// -----------------------------------------------------------------------------
interface csr_regfile_if #(
   parameter int XLEN = 32
);
   logic            csr_req_i;
   logic            csr_we_i;
   logic [1:0]      csr_op_i;
   logic [11:0]     csr_addr_i;
   logic [XLEN-1:0] csr_wdata_i;
   logic [XLEN-1:0] csr_rdata_o;
   logic            csr_illegal_o;

   modport master (
      output csr_req_i, csr_we_i, csr_op_i, csr_addr_i, csr_wdata_i,
      input  csr_rdata_o, csr_illegal_o
   );

   modport slave (
      input  csr_req_i, csr_we_i, csr_op_i, csr_addr_i, csr_wdata_i,
      output csr_rdata_o, csr_illegal_o
   );
endinterface

// File: rtl/csr_regfile.sv
// -----------------------------------------------------------------------------
// csr_regfile
//   Machine-mode CSR file: ex read-modify-write port, trap entry / mret
//   updates, interrupt pending, vectored trap target, cycle/instret counters.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   csr                 : CSR access port (slave side)
//   trap_i/trap_cause_i/trap_pc_i : trap entry strobe, mcause value, PC
//   mret_i              : mret retire strobe
//   instret_i           : one instruction retired
//   irq_ext_i/irq_timer_i/irq_sw_i : interrupt levels
//   mtvec_o, mepc_o     : current mtvec / mepc
//   trap_target_o       : trap vector for trap_cause_i
//   global_int_en_o     : mstatus.MIE
//   int_pending_o       : MIE & |(mie & mip)
// -----------------------------------------------------------------------------
module csr_regfile #(
   parameter int              XLEN           = 32,
   parameter int              CNT_WIDTH      = 64,
   parameter bit              MTVEC_VECTORED = 1'b1,
   parameter logic [XLEN-1:0] RESET_MTVEC    = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   csr_regfile_if.slave    csr,
   input  logic            trap_i,
   input  logic [XLEN-1:0] trap_cause_i,
   input  logic [XLEN-1:0] trap_pc_i,
   input  logic            mret_i,
   input  logic            instret_i,
   input  logic            irq_ext_i,
   input  logic            irq_timer_i,
   input  logic            irq_sw_i,
   output logic [XLEN-1:0] mtvec_o,
   output logic [XLEN-1:0] mepc_o,
   output logic [XLEN-1:0] trap_target_o,
   output logic            global_int_en_o,
   output logic            int_pending_o
);

   localparam logic [XLEN-1:0] MIE_MASK   = XLEN'(12'h888);
   localparam logic [XLEN-1:0] CINH_MASK  = XLEN'(3'b101);
   localparam logic [XLEN-1:0] MTVEC_MASK = {{(XLEN-2){1'b1}}, 1'b0, MTVEC_VECTORED};
   localparam logic [XLEN-1:0] MEPC_MASK  = {{(XLEN-2){1'b1}}, 2'b00};

   logic                 r_mstatus_mie;
   logic                 r_mstatus_mpie;
   logic [XLEN-1:0]      r_mie;
   logic [XLEN-1:0]      r_mtvec;
   logic [XLEN-1:0]      r_mcountinhibit;
   logic [XLEN-1:0]      r_mscratch;
   logic [XLEN-1:0]      r_mepc;
   logic [XLEN-1:0]      r_mcause;
   logic [XLEN-1:0]      r_mip;
   logic [CNT_WIDTH-1:0] r_mcycle;
   logic [CNT_WIDTH-1:0] r_minstret;

   logic [XLEN-1:0]      w_mstatus;
   logic [2*XLEN-1:0]    w_cyc_x;
   logic [2*XLEN-1:0]    w_ins_x;
   logic [XLEN-1:0]      w_old;
   logic [XLEN-1:0]      w_new;
   logic                 w_mapped;
   logic                 w_illegal;
   logic                 w_wr;
   logic [XLEN-1:0]      w_base;

   // MPP is hardwired to machine mode (bits 12:11)
   assign w_mstatus = XLEN'({2'b11, 3'b000, r_mstatus_mpie, 3'b000, r_mstatus_mie, 3'b000});

   // Zero-extend counters to 2*XLEN so the high half reads 0 above CNT_WIDTH
   assign w_cyc_x = (2*XLEN)'(r_mcycle);
   assign w_ins_x = (2*XLEN)'(r_minstret);

   always_comb begin
      w_mapped = 1'b1;
      w_old    = '0;
      case (csr.csr_addr_i)
         12'h300: w_old = w_mstatus;
         12'h304: w_old = r_mie;
         12'h305: w_old = r_mtvec;
         12'h320: w_old = r_mcountinhibit;
         12'h340: w_old = r_mscratch;
         12'h341: w_old = r_mepc;
         12'h342: w_old = r_mcause;
         12'h344: w_old = r_mip;
         12'hB00, 12'hC00: w_old = w_cyc_x[XLEN-1:0];
         12'hB80, 12'hC80: w_old = w_cyc_x[2*XLEN-1:XLEN];
         12'hB02, 12'hC02: w_old = w_ins_x[XLEN-1:0];
         12'hB82, 12'hC82: w_old = w_ins_x[2*XLEN-1:XLEN];
         default: w_mapped = 1'b0;
      endcase
   end

   assign w_illegal = csr.csr_req_i &
                      (~w_mapped | (csr.csr_we_i & (csr.csr_addr_i[11:10] == 2'b11)));
   assign csr.csr_illegal_o = w_illegal;
   assign csr.csr_rdata_o   = w_old;

   always_comb begin
      case (csr.csr_op_i)
         2'b10:   w_new = w_old | csr.csr_wdata_i;
         2'b11:   w_new = w_old & ~csr.csr_wdata_i;
         default: w_new = csr.csr_wdata_i;
      endcase
   end

   // A trap or mret squashes the ex instruction entirely
   assign w_wr = csr.csr_req_i & csr.csr_we_i & (csr.csr_op_i != 2'b00) &
                 ~w_illegal & ~trap_i & ~mret_i;

   logic w_we_mstatus, w_we_mie, w_we_mtvec, w_we_cinh, w_we_mscratch;
   logic w_we_mepc, w_we_mcause, w_we_cyc_lo, w_we_cyc_hi, w_we_ins_lo, w_we_ins_hi;

   assign w_we_mstatus  = w_wr & (csr.csr_addr_i == 12'h300);
   assign w_we_mie      = w_wr & (csr.csr_addr_i == 12'h304);
   assign w_we_mtvec    = w_wr & (csr.csr_addr_i == 12'h305);
   assign w_we_cinh     = w_wr & (csr.csr_addr_i == 12'h320);
   assign w_we_mscratch = w_wr & (csr.csr_addr_i == 12'h340);
   assign w_we_mepc     = w_wr & (csr.csr_addr_i == 12'h341);
   assign w_we_mcause   = w_wr & (csr.csr_addr_i == 12'h342);
   assign w_we_cyc_lo   = w_wr & (csr.csr_addr_i == 12'hB00);
   assign w_we_cyc_hi   = w_wr & (csr.csr_addr_i == 12'hB80);
   assign w_we_ins_lo   = w_wr & (csr.csr_addr_i == 12'hB02);
   assign w_we_ins_hi   = w_wr & (csr.csr_addr_i == 12'hB82);

   // mstatus / mepc / mcause: trap > mret > ex write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mstatus_mie  <= 1'b0;
         r_mstatus_mpie <= 1'b0;
         r_mepc         <= '0;
         r_mcause       <= '0;
      end else if (trap_i) begin
         r_mstatus_mpie <= r_mstatus_mie;
         r_mstatus_mie  <= 1'b0;
         r_mepc         <= trap_pc_i & MEPC_MASK;
         r_mcause       <= trap_cause_i;
      end else if (mret_i) begin
         r_mstatus_mie  <= r_mstatus_mpie;
         r_mstatus_mpie <= 1'b1;
      end else begin
         if (w_we_mstatus) begin
            r_mstatus_mie  <= w_new[3];
            r_mstatus_mpie <= w_new[7];
         end
         if (w_we_mepc)   r_mepc   <= w_new & MEPC_MASK;
         if (w_we_mcause) r_mcause <= w_new;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mie           <= '0;
         r_mtvec         <= RESET_MTVEC;
         r_mcountinhibit <= '0;
         r_mscratch      <= '0;
         r_mip           <= '0;
      end else begin
         if (w_we_mie)      r_mie           <= w_new & MIE_MASK;
         if (w_we_mtvec)    r_mtvec         <= w_new & MTVEC_MASK;
         if (w_we_cinh)     r_mcountinhibit <= w_new & CINH_MASK;
         if (w_we_mscratch) r_mscratch      <= w_new;
         // mip mirrors the interrupt lines; software writes are ignored
         r_mip <= XLEN'({irq_ext_i, 3'b000, irq_timer_i, 3'b000, irq_sw_i, 3'b000});
      end
   end

   // A written counter holds the written value for one cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_mcycle <= '0;
      else if (w_we_cyc_lo)
         r_mcycle[XLEN-1:0] <= w_new;
      else if (w_we_cyc_hi)
         r_mcycle[CNT_WIDTH-1:XLEN] <= w_new[CNT_WIDTH-XLEN-1:0];
      else if (!r_mcountinhibit[0])
         r_mcycle <= r_mcycle + CNT_WIDTH'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_minstret <= '0;
      else if (w_we_ins_lo)
         r_minstret[XLEN-1:0] <= w_new;
      else if (w_we_ins_hi)
         r_minstret[CNT_WIDTH-1:XLEN] <= w_new[CNT_WIDTH-XLEN-1:0];
      else if (!r_mcountinhibit[2] && instret_i)
         r_minstret <= r_minstret + CNT_WIDTH'(1);
   end

   // Vectored interrupts land at base + 4*cause; exceptions always use base
   assign w_base        = {r_mtvec[XLEN-1:2], 2'b00};
   assign trap_target_o = (r_mtvec[0] && trap_cause_i[XLEN-1])
                        ? w_base + {trap_cause_i[XLEN-3:0], 2'b00}
                        : w_base;

   assign mtvec_o         = r_mtvec;
   assign mepc_o          = r_mepc;
   assign global_int_en_o = r_mstatus_mie;
   assign int_pending_o   = r_mstatus_mie & |(r_mie & r_mip);

endmodule

// File: tb/tb_csr_regfile.sv
// -----------------------------------------------------------------------------
// tb_csr_regfile
//   Scoreboard bench for csr_regfile: stimulus pushes expected outputs from a
//   behavioural CSR model; a negedge monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_csr_regfile;

   logic        clk, rst_n;
   logic        trap_i, mret_i, instret_i;
   logic [31:0] trap_cause_i, trap_pc_i;
   logic        irq_ext_i, irq_timer_i, irq_sw_i;
   logic [31:0] mtvec_o, mepc_o, trap_target_o;
   logic        global_int_en_o, int_pending_o;

   csr_regfile_if #(.XLEN(32)) bus ();

   csr_regfile #(.XLEN(32), .CNT_WIDTH(64), .MTVEC_VECTORED(1'b1), .RESET_MTVEC(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .csr(bus),
      .trap_i(trap_i), .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i),
      .mret_i(mret_i), .instret_i(instret_i),
      .irq_ext_i(irq_ext_i), .irq_timer_i(irq_timer_i), .irq_sw_i(irq_sw_i),
      .mtvec_o(mtvec_o), .mepc_o(mepc_o), .trap_target_o(trap_target_o),
      .global_int_en_o(global_int_en_o), .int_pending_o(int_pending_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   bit              m_mie, m_mpie;
   bit [31:0]       m_miereg, m_mtvec, m_inh, m_scratch, m_mepc, m_mcause, m_mip;
   longint unsigned m_cyc, m_ins;

   function automatic void model_reset();
      m_mie = 0; m_mpie = 0; m_miereg = 0; m_mtvec = 0; m_inh = 0;
      m_scratch = 0; m_mepc = 0; m_mcause = 0; m_mip = 0; m_cyc = 0; m_ins = 0;
   endfunction

   function automatic bit [31:0] mread(input bit [11:0] a, output bit mapped);
      mapped = 1;
      case (a)
         12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
         12'h304: return m_miereg;
         12'h305: return m_mtvec;
         12'h320: return m_inh;
         12'h340: return m_scratch;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'h344: return m_mip;
         12'hB00, 12'hC00: return m_cyc[31:0];
         12'hB80, 12'hC80: return m_cyc[63:32];
         12'hB02, 12'hC02: return m_ins[31:0];
         12'hB82, 12'hC82: return m_ins[63:32];
         default: begin mapped = 0; return 0; end
      endcase
   endfunction

   function automatic bit model_illegal(input bit [11:0] a, input bit req, input bit we);
      bit mp;
      bit [31:0] d;
      d = mread(a, mp);
      return req && (!mp || (we && a[11:10] == 2'b11));
   endfunction

   task automatic model_step();
      bit mp, wr, cw, iw;
      bit [11:0] a;
      bit [31:0] old, nv, w;
      if (!rst_n) begin model_reset(); return; end
      a   = bus.csr_addr_i;
      w   = bus.csr_wdata_i;
      old = mread(a, mp);
      wr  = bus.csr_req_i && bus.csr_we_i && bus.csr_op_i != 2'b00 &&
            !model_illegal(a, bus.csr_req_i, bus.csr_we_i) && !trap_i && !mret_i;
      case (bus.csr_op_i)
         2'b10:   nv = old | w;
         2'b11:   nv = old & ~w;
         default: nv = w;
      endcase
      cw = wr && (a == 12'hB00 || a == 12'hB80);
      iw = wr && (a == 12'hB02 || a == 12'hB82);
      if (cw) begin
         if (a == 12'hB00) m_cyc[31:0] = nv; else m_cyc[63:32] = nv;
      end else if (!m_inh[0]) m_cyc = m_cyc + 1;
      if (iw) begin
         if (a == 12'hB02) m_ins[31:0] = nv; else m_ins[63:32] = nv;
      end else if (!m_inh[2] && instret_i) m_ins = m_ins + 1;
      m_mip = (32'(irq_ext_i) << 11) | (32'(irq_timer_i) << 7) | (32'(irq_sw_i) << 3);
      if (trap_i) begin
         m_mepc = trap_pc_i & ~32'h3; m_mcause = trap_cause_i;
         m_mpie = m_mie; m_mie = 0;
      end else if (mret_i) begin
         m_mie = m_mpie; m_mpie = 1;
      end else if (wr) begin
         case (a)
            12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
            12'h304: m_miereg  = nv & 32'h888;
            12'h305: m_mtvec   = nv & 32'hFFFF_FFFD;
            12'h320: m_inh     = nv & 32'h5;
            12'h340: m_scratch = nv;
            12'h341: m_mepc    = nv & ~32'h3;
            12'h342: m_mcause  = nv;
            default: ;
         endcase
      end
   endtask

   // ---------------- scoreboard ----------------
   typedef struct {
      bit        rd;
      bit [31:0] rdata;
      bit        ill;
      bit [31:0] mtvec, mepc, target;
      bit        gie, ip;
   } exp_t;

   exp_t scb[$];
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (scb.size() > 0) begin
            e = scb.pop_front();
            if (e.rd) begin
               chk("rdata", bus.csr_rdata_o, e.rdata);
               chk("illegal", 32'(bus.csr_illegal_o), 32'(e.ill));
            end
            chk("mtvec_o", mtvec_o, e.mtvec);
            chk("mepc_o", mepc_o, e.mepc);
            chk("trap_target_o", trap_target_o, e.target);
            chk("global_int_en_o", 32'(global_int_en_o), 32'(e.gie));
            chk("int_pending_o", 32'(int_pending_o), 32'(e.ip));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      exp_t e;
      bit mp;
      bit [31:0] base;
      if (!rst_n) model_reset();
      e.rd    = bus.csr_req_i;
      e.rdata = mread(bus.csr_addr_i, mp);
      e.ill   = model_illegal(bus.csr_addr_i, bus.csr_req_i, bus.csr_we_i);
      e.mtvec = m_mtvec;
      e.mepc  = m_mepc;
      e.gie   = m_mie;
      e.ip    = m_mie && ((m_miereg & m_mip) != 0);
      base    = m_mtvec & ~32'h3;
      e.target = (m_mtvec[0] && trap_cause_i[31]) ? base + 4 * trap_cause_i : base;
      scb.push_back(e);
      @(posedge clk);
      model_step();
      #1;
      bus.csr_req_i = 0; bus.csr_we_i = 0; bus.csr_op_i = 0;
      trap_i = 0; mret_i = 0; instret_i = 0;
   endtask

   task automatic acc(input bit [1:0] op, input bit we, input bit [11:0] a, input bit [31:0] d);
      bus.csr_req_i = 1; bus.csr_we_i = we; bus.csr_op_i = op;
      bus.csr_addr_i = a; bus.csr_wdata_i = d;
      tick();
   endtask

   task automatic rd(input bit [11:0] a);
      acc(2'b10, 1'b0, a, 32'h0);
   endtask

   bit [11:0] addrs [18] = '{12'h300, 12'h304, 12'h305, 12'h320, 12'h340, 12'h341,
                            12'h342, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
                            12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h7C0, 12'h123};

   initial begin
      model_reset();
      rst_n = 0;
      bus.csr_req_i = 0; bus.csr_we_i = 0; bus.csr_op_i = 0;
      bus.csr_addr_i = 0; bus.csr_wdata_i = 0;
      trap_i = 0; mret_i = 0; instret_i = 0; trap_cause_i = 0; trap_pc_i = 0;
      irq_ext_i = 0; irq_timer_i = 0; irq_sw_i = 0;
      @(posedge clk); #1;
      repeat (3) tick();
      rst_n = 1;

      // reset values
      rd(12'h300); rd(12'h305); rd(12'hB00);

      // RW / RS / RC read-modify-write on mscratch
      acc(2'b01, 1, 12'h340, 32'hDEADBEEF);
      acc(2'b10, 1, 12'h340, 32'h0000FFFF);
      acc(2'b11, 1, 12'h340, 32'hFFFF0000);
      rd(12'h340);

      // illegal accesses
      acc(2'b01, 1, 12'hC00, 32'h1234);
      rd(12'hC00);
      rd(12'h7C0);
      acc(2'b01, 1, 12'h344, 32'hFFFF_FFFF);   // mip write ignored, not illegal
      rd(12'h344);

      // interrupt pending, trap, mret
      acc(2'b10, 1, 12'h300, 32'h8);
      acc(2'b10, 1, 12'h304, 32'h80);
      irq_timer_i = 1;
      tick(); tick();
      acc(2'b01, 1, 12'h305, 32'h1001);
      trap_cause_i = 32'h8000_0007; trap_pc_i = 32'h106; trap_i = 1;
      tick();
      rd(12'h341); rd(12'h300); rd(12'h342);
      mret_i = 1; tick();
      rd(12'h300);
      irq_timer_i = 0;

      // counter wrap and inhibit
      acc(2'b01, 1, 12'hB02, 32'hFFFF_FFFF);
      acc(2'b01, 1, 12'hB82, 32'h0);
      instret_i = 1; tick();
      rd(12'hB02); rd(12'hB82);
      acc(2'b01, 1, 12'h320, 32'h5);
      instret_i = 1; rd(12'hB00);
      instret_i = 1; rd(12'hB00);
      rd(12'hB02);
      acc(2'b01, 1, 12'h320, 32'h0);
      acc(2'b01, 1, 12'hB80, 32'hFFFF_FFFF);
      acc(2'b01, 1, 12'hB00, 32'hFFFF_FFFE);
      tick(); tick();
      rd(12'hB00); rd(12'hB80);

      // trap + mret + ex write together: only the trap lands
      trap_cause_i = 32'h0000_0002; trap_pc_i = 32'h2223; trap_i = 1; mret_i = 1;
      acc(2'b01, 1, 12'h341, 32'h5555_5554);
      rd(12'h341); rd(12'h300);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         irq_ext_i   = 1'($urandom_range(0, 1));
         irq_timer_i = 1'($urandom_range(0, 1));
         irq_sw_i    = 1'($urandom_range(0, 1));
         instret_i   = 1'($urandom_range(0, 1));
         trap_i      = ($urandom_range(0, 15) == 0);
         mret_i      = ($urandom_range(0, 15) == 0);
         trap_cause_i = {1'($urandom_range(0, 1)), 31'($urandom_range(0, 15))};
         trap_pc_i    = $urandom;
         bus.csr_req_i  = 1'($urandom_range(0, 1));
         bus.csr_we_i   = 1'($urandom_range(0, 1));
         bus.csr_op_i   = 2'($urandom_range(0, 3));
         bus.csr_addr_i = addrs[$urandom_range(0, 17)];
         bus.csr_wdata_i = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
         tick();
      end

      // reset asserted mid-operation alongside a trap
      acc(2'b01, 1, 12'h340, 32'hA5A5_A5A5);
      rst_n = 0; trap_i = 1; trap_pc_i = 32'h4000; trap_cause_i = 32'h8000_0003;
      tick();
      rst_n = 1;
      rd(12'h340); rd(12'h341); rd(12'h300); rd(12'hB02);

      @(negedge clk); @(negedge clk);
      checks++;
      if (scb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", scb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
